// File: rtl/stopwatch_pkg.sv
// Shared stopwatch definitions: FSM state encodings and count limits.
// Used by the seconds stage and the downstream minutes counter.
// Contents: sw_state_e (IDLE/RUNNING/PAUSED), SEC_MAX, MIN_MAX.
package stopwatch_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RUNNING = 2'd1,
        ST_PAUSED  = 2'd2
    } sw_state_e;

    localparam logic [5:0] SEC_MAX = 6'd59;
    localparam logic [6:0] MIN_MAX = 7'd99;

endpackage

// File: rtl/tick_prescaler.sv
// Purpose: divides clk by DIV and flags the last cycle of each period.
// Ports: clk, rst_n (async, active-low), clr (sync clear), en (count enable),
//        tick (combinational, high while enabled and on the count's last value).
module tick_prescaler #(
    parameter int DIV = 100_000_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic tick
);

    // At least one bit, so DIV = 1 still produces a legal (constant zero) counter.
    localparam int              CW   = (DIV < 2) ? 1 : $clog2(DIV);
    localparam logic [CW-1:0]   LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    assign tick = en & (cnt_q == LAST);

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = (cnt_q == LAST) ? '0 : cnt_q + CW'(1);
        end
        // Disabled and not cleared: hold, preserving the fractional second.
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/seconds_timebase.sv
// Purpose: stopwatch seconds stage; one-second timebase plus 0..59 counter
//          with start/stop/clear control and a combinational minute strobe.
// Ports: clk, rst_n (async clear), reset (sync clear), start, stop ->
//        seconds[5:0], running, sec_tick, inc_min.
module seconds_timebase
    import stopwatch_pkg::*;
#(
    parameter int DIV = 100_000_000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       reset,
    input  logic       start,
    input  logic       stop,
    output logic [5:0] seconds,
    output logic       running,
    output logic       sec_tick,
    output logic       inc_min
);

    sw_state_e  state_q;
    logic       running_q;
    logic [5:0] seconds_q;
    logic [5:0] seconds_d;
    logic       pre_tick;
    logic       pre_clr;
    logic       pre_en;

    assign pre_en  = (state_q == ST_RUNNING);
    assign pre_clr = reset | (state_q == ST_IDLE);

    tick_prescaler #(.DIV(DIV)) u_prescaler (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (pre_clr),
        .en    (pre_en),
        .tick  (pre_tick)
    );

    // Strobes come from current state so a coincident stop still lets the
    // tick land; a synchronous clear suppresses them in that same cycle.
    assign sec_tick = pre_en & pre_tick & ~reset;
    assign inc_min  = sec_tick & (seconds_q == SEC_MAX);

    always_comb begin
        seconds_d = seconds_q;
        if (sec_tick) begin
            seconds_d = (seconds_q == SEC_MAX) ? 6'd0 : seconds_q + 6'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            running_q <= 1'b0;
            seconds_q <= 6'd0;
        end else if (reset) begin
            state_q   <= ST_IDLE;
            running_q <= 1'b0;
            seconds_q <= 6'd0;
        end else begin
            seconds_q <= seconds_d;
            case (state_q)
                ST_IDLE, ST_PAUSED: begin
                    if (start && !stop) begin
                        state_q   <= ST_RUNNING;
                        running_q <= 1'b1;
                    end
                end
                ST_RUNNING: begin
                    if (stop && !start) begin
                        state_q   <= ST_PAUSED;
                        running_q <= 1'b0;
                    end
                end
                default: begin
                    state_q   <= ST_IDLE;
                    running_q <= 1'b0;
                end
            endcase
        end
    end

    assign seconds = seconds_q;
    assign running = running_q;

endmodule

// File: tb/tb_seconds_timebase.sv
module tb_seconds_timebase;

    localparam int DIV = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       reset;
    logic       start;
    logic       stop;
    logic [5:0] seconds;
    logic       running;
    logic       sec_tick;
    logic       inc_min;

    // Downstream minutes counter sharing clk, rst_n and reset.
    logic [6:0] min_q;

    int checks = 0;
    int errors = 0;

    // Reference model: mode 0 idle, 1 running, 2 paused; phase = cycles into current second.
    int m_mode  = 0;
    int m_sec   = 0;
    int m_min   = 0;
    int m_phase = 0;

    logic obs_tick;
    logic obs_inc;

    always #5 clk = ~clk;

    seconds_timebase #(.DIV(DIV)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .reset    (reset),
        .start    (start),
        .stop     (stop),
        .seconds  (seconds),
        .running  (running),
        .sec_tick (sec_tick),
        .inc_min  (inc_min)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)       min_q <= 7'd0;
        else if (reset)   min_q <= 7'd0;
        else if (inc_min) min_q <= (min_q == 7'd99) ? 7'd0 : min_q + 7'd1;
    end

    task automatic model_clear();
        m_mode = 0; m_sec = 0; m_min = 0; m_phase = 0;
    endtask

    // One clock cycle: drive inputs after the falling edge, check all outputs
    // against the model, then advance the model across the rising edge.
    task automatic step(input logic s, input logic p, input logic r, input string tag);
        logic exp_tick;
        logic exp_inc;
        start = s; stop = p; reset = r;
        #1;
        exp_tick = (m_mode == 1) && (m_phase == DIV - 1) && !r;
        exp_inc  = exp_tick && (m_sec == 59);
        checks += 5;
        if (seconds !== 6'(m_sec)) begin
            errors++; $display("FAIL %s seconds: got %0d expected %0d", tag, seconds, m_sec);
        end
        if (running !== (m_mode == 1)) begin
            errors++; $display("FAIL %s running: got %b expected %b", tag, running, m_mode == 1);
        end
        if (sec_tick !== exp_tick) begin
            errors++; $display("FAIL %s sec_tick: got %b expected %b", tag, sec_tick, exp_tick);
        end
        if (inc_min !== exp_inc) begin
            errors++; $display("FAIL %s inc_min: got %b expected %b", tag, inc_min, exp_inc);
        end
        if (min_q !== 7'(m_min)) begin
            errors++; $display("FAIL %s minutes: got %0d expected %0d", tag, min_q, m_min);
        end
        obs_tick = sec_tick;
        obs_inc  = inc_min;
        @(posedge clk);
        if (r) begin
            model_clear();
        end else begin
            if (exp_tick) m_sec = (m_sec + 1) % 60;
            if (exp_inc)  m_min = (m_min + 1) % 100;
            if (m_mode == 0)      m_phase = 0;
            else if (m_mode == 1) m_phase = (m_phase + 1) % DIV;
            if ((m_mode == 0 || m_mode == 2) && s && !p) m_mode = 1;
            else if (m_mode == 1 && p && !s)             m_mode = 2;
        end
        @(negedge clk);
    endtask

    // Idle-step until running with the given phase (and seconds, if sec >= 0).
    task automatic run_until(input int ph, input int sec, input int limit, input string tag);
        int n = 0;
        while (!(m_mode == 1 && m_phase == ph && (sec < 0 || m_sec == sec)) && n < limit) begin
            step(1'b0, 1'b0, 1'b0, tag);
            n++;
        end
        checks++;
        if (n >= limit) begin
            errors++; $display("FAIL %s timeout: waited %0d cycles, limit %0d", tag, n, limit);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; reset = 1'b0; start = 1'b0; stop = 1'b0;
        model_clear();
        repeat (3) @(negedge clk);
        checks++;
        if ({seconds, running, sec_tick, inc_min} !== 9'd0) begin
            errors++; $display("FAIL reset_values: got %b expected 0", {seconds, running, sec_tick, inc_min});
        end
        rst_n = 1'b1;
        repeat (3) step(1'b0, 1'b0, 1'b0, "reset_idle");
    endtask

    task automatic test_start_count();
        step(1'b1, 1'b0, 1'b0, "start_pulse");
        for (int i = 1; i <= 12; i++) begin
            step(1'b0, 1'b0, 1'b0, "count");
            checks++;
            if (obs_tick !== (i % 4 == 0)) begin
                errors++; $display("FAIL count_tick_cycle%0d: got %b expected %b", i, obs_tick, i % 4 == 0);
            end
        end
        checks++;
        if (seconds !== 6'd3) begin
            errors++; $display("FAIL count_after_12: got %0d expected 3", seconds);
        end
    endtask

    task automatic test_wrap();
        int incs = 0;
        run_until(DIV - 1, 59, 400, "wrap_seek");
        checks++;
        if (inc_min !== 1'b1 || min_q !== 7'd0) begin
            errors++; $display("FAIL wrap_pre: got inc_min=%b min=%0d expected inc_min=1 min=0", inc_min, min_q);
        end
        step(1'b0, 1'b0, 1'b0, "wrap_edge");
        checks++;
        if (seconds !== 6'd0 || min_q !== 7'd1) begin
            errors++; $display("FAIL wrap_post: got sec=%0d min=%0d expected sec=0 min=1", seconds, min_q);
        end
        for (int i = 0; i < 3 * DIV; i++) begin
            step(1'b0, 1'b0, 1'b0, "wrap_after");
            if (obs_inc) incs++;
        end
        checks++;
        if (incs != 0) begin
            errors++; $display("FAIL wrap_extra_inc: got %0d expected 0", incs);
        end
    endtask

    task automatic test_pause_resume();
        int held_sec;
        int n = 0;
        run_until(1, -1, 20, "pause_seek");
        step(1'b0, 1'b1, 1'b0, "pause_stop");
        held_sec = m_sec;
        repeat (10) step(1'b0, 1'b0, 1'b0, "paused");
        checks++;
        if (seconds !== 6'(held_sec) || running !== 1'b0) begin
            errors++; $display("FAIL pause_frozen: got sec=%0d run=%b expected sec=%0d run=0", seconds, running, held_sec);
        end
        step(1'b1, 1'b0, 1'b0, "resume");
        obs_tick = 1'b0;
        while (!obs_tick && n < 10) begin
            step(1'b0, 1'b0, 1'b0, "resume_run");
            n++;
        end
        checks++;
        if (n != 2) begin
            errors++; $display("FAIL resume_tick_cycle: got %0d expected 2", n);
        end
    endtask

    task automatic test_sync_reset_wrap();
        run_until(DIV - 1, 59, 400, "sreset_seek");
        step(1'b0, 1'b0, 1'b1, "sreset_edge");
        checks++;
        if (obs_inc !== 1'b0 || obs_tick !== 1'b0) begin
            errors++; $display("FAIL sreset_strobes: got tick=%b inc=%b expected 0 0", obs_tick, obs_inc);
        end
        checks++;
        if (seconds !== 6'd0 || running !== 1'b0 || min_q !== 7'd0) begin
            errors++; $display("FAIL sreset_after: got sec=%0d run=%b min=%0d expected 0 0 0", seconds, running, min_q);
        end
        repeat (2 * DIV) step(1'b0, 1'b0, 1'b0, "sreset_idle");
    endtask

    task automatic test_async_reset();
        step(1'b1, 1'b0, 1'b0, "areset_start");
        run_until(1, 17, 200, "areset_seek");
        #3 rst_n = 1'b0;
        #1;
        checks++;
        if ({seconds, running, sec_tick, inc_min} !== 9'd0 || min_q !== 7'd0) begin
            errors++; $display("FAIL areset_immediate: got sec=%0d run=%b tick=%b inc=%b min=%0d expected all 0",
                               seconds, running, sec_tick, inc_min, min_q);
        end
        model_clear();
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3 * DIV) step(1'b0, 1'b0, 1'b0, "areset_idle");
        checks++;
        if (seconds !== 6'd0) begin
            errors++; $display("FAIL areset_no_count: got %0d expected 0", seconds);
        end
    endtask

    task automatic test_control_edges();
        int prev;
        step(1'b1, 1'b1, 1'b0, "both_idle");
        checks++;
        if (running !== 1'b0) begin
            errors++; $display("FAIL both_idle: got running=%b expected 0", running);
        end
        step(1'b1, 1'b0, 1'b0, "edge_start");
        step(1'b1, 1'b1, 1'b0, "both_running");
        checks++;
        if (running !== 1'b1) begin
            errors++; $display("FAIL both_running: got running=%b expected 1", running);
        end
        run_until(DIV - 1, -1, 20, "stop_tick_seek");
        prev = m_sec;
        step(1'b0, 1'b1, 1'b0, "stop_on_tick");
        checks++;
        if (obs_tick !== 1'b1 || seconds !== 6'((prev + 1) % 60) || running !== 1'b0) begin
            errors++; $display("FAIL stop_on_tick: got tick=%b sec=%0d run=%b expected 1 %0d 0",
                               obs_tick, seconds, running, (prev + 1) % 60);
        end
        repeat (DIV) step(1'b0, 1'b0, 1'b0, "stop_on_tick_hold");
    endtask

    task automatic test_random();
        for (int i = 0; i < 2000; i++) begin
            step($urandom_range(0, 7) == 0, $urandom_range(0, 15) == 0,
                 $urandom_range(0, 199) == 0, "random");
        end
    endtask

    initial begin
        test_reset();
        test_start_count();
        test_wrap();
        test_pause_resume();
        test_sync_reset_wrap();
        test_async_reset();
        test_control_edges();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
